// File: rtl/serial_tx_scheduler_if.sv
// Handshake and line signals between the two message producers and the serial
// transmit scheduler.
//
// Handshake: REQx acts as the valid and is a level. DATAx must stay stable while
// REQx is high. GNTx is the ready: a one-cycle pulse in the cycle after the edge
// that captured DATAx. Dropping REQx before the grant withdraws the request.
interface serial_tx_scheduler_if #(
  parameter int FRAME_W = 12
) ();
  logic               REQ0;
  logic [FRAME_W-1:0] DATA0;
  logic               REQ1;
  logic [FRAME_W-1:0] DATA1;
  logic               GNT0;
  logic               GNT1;
  logic               BUSY;
  logic               TXD;

  modport master (
    output REQ0, DATA0, REQ1, DATA1,
    input  GNT0, GNT1, BUSY, TXD
  );

  modport slave (
    input  REQ0, DATA0, REQ1, DATA1,
    output GNT0, GNT1, BUSY, TXD
  );
endinterface

// File: rtl/serial_tx_scheduler.sv
// Round-robin sharing of one serial line between two frame producers: MSB-first
// serialisation at the bit rate, a fixed idle gap after each frame, all-ones frames dropped.
module serial_tx_scheduler #(
  parameter int BAUD_DIV = 5208,
  parameter int FRAME_W  = 12,
  parameter int GAP_BITS = 960
) (
  input  logic                  CLK,
  input  logic                  RESET,
  serial_tx_scheduler_if.slave  bus,
  output logic [1:0]            state_dbg
);
  localparam int BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int GAP_W  = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [3:0]        BIT_LAST  = 4'(FRAME_W - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [FRAME_W-1:0]   sr_q, sr_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 pri_q, pri_d;
  logic                 gnt0_q, gnt0_d;
  logic                 gnt1_q, gnt1_d;
  logic                 baud_wrap;
  logic                 grant0, grant1;
  logic [FRAME_W-1:0]   sel_data;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      sr_q    <= '1;
      baud_q  <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      pri_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      pri_q   <= pri_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    gap_d     = gap_q;
    pri_d     = pri_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    baud_wrap = (baud_q == BAUD_LAST);
    // PRI names the requester that wins when both are asking.
    grant0    = bus.REQ0 && (!bus.REQ1 || !pri_q);
    grant1    = bus.REQ1 && (!bus.REQ0 || pri_q);
    sel_data  = grant0 ? bus.DATA0 : bus.DATA1;

    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          sr_d   = sel_data;
          gnt0_d = grant0;
          gnt1_d = grant1;
          pri_d  = grant0;
          // An all-ones frame is the producer's "nothing to say": accept, don't send.
          if (sel_data != '1) state_d = SHIFT;
        end
      end
      SHIFT: begin
        baud_d = baud_wrap ? '0 : baud_q + 1'b1;
        if (baud_wrap) begin
          sr_d = {sr_q[FRAME_W-2:0], 1'b1};
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = GAP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      GAP: begin
        baud_d = baud_wrap ? '0 : baud_q + 1'b1;
        if (baud_wrap) begin
          if (gap_q == GAP_LAST) begin
            gap_d   = '0;
            state_d = IDLE;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.TXD   = (state_q == SHIFT) ? sr_q[FRAME_W-1] : 1'b1;
  assign bus.BUSY  = (state_q != IDLE);
  assign bus.GNT0  = gnt0_q;
  assign bus.GNT1  = gnt1_q;
  assign state_dbg = state_q;
endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Bench for serial_tx_scheduler: a line-level model (queue of expected TXD levels)
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_serial_tx_scheduler;
  localparam int BD = 4;
  localparam int FW = 12;
  localparam int GB = 2;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic rst2 = 1'b0;
  always #5 CLK = ~CLK;

  serial_tx_scheduler_if #(.FRAME_W(FW)) bus ();
  serial_tx_scheduler_if #(.FRAME_W(12)) bus2 ();
  logic [1:0] state_dbg;
  logic [1:0] state_dbg2;

  serial_tx_scheduler #(.BAUD_DIV(BD), .FRAME_W(FW), .GAP_BITS(GB)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus), .state_dbg(state_dbg)
  );

  serial_tx_scheduler dut2 (
    .CLK(CLK), .RESET(rst2), .bus(bus2), .state_dbg(state_dbg2)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int fail_prints = 0;
  int cyc = 0;
  logic check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (fail_prints < 40) begin
        fail_prints++;
        $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
      end
    end
  endtask

  // Model: the line is a queue of per-cycle levels filled when a frame is granted.
  logic [0:0]    exp_q[$];
  logic          m_pri = 1'b0;
  logic          m_gnt0 = 1'b0;
  logic          m_gnt1 = 1'b0;
  logic          m_g0, m_g1;
  logic [FW-1:0] m_data;

  always @(posedge CLK) begin
    cyc++;
    m_gnt0 = 1'b0;
    m_gnt1 = 1'b0;
    if (!RESET) begin
      exp_q.delete();
      m_pri = 1'b0;
    end else if (exp_q.size() != 0) begin
      exp_q.delete(0);
    end else begin
      m_g0 = bus.REQ0 && (!bus.REQ1 || !m_pri);
      m_g1 = bus.REQ1 && (!bus.REQ0 || m_pri);
      if (m_g0 || m_g1) begin
        m_data = m_g0 ? bus.DATA0 : bus.DATA1;
        m_gnt0 = m_g0;
        m_gnt1 = m_g1;
        m_pri  = m_g0;
        if (m_data != {FW{1'b1}}) begin
          for (int b = FW - 1; b >= 0; b--)
            for (int r = 0; r < BD; r++) exp_q.push_back(m_data[b]);
          for (int r = 0; r < GB * BD; r++) exp_q.push_back(1'b1);
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (check_en) begin
      check("txd", bus.TXD, (exp_q.size() != 0) ? exp_q[0] : 1'b1);
      check("busy", bus.BUSY, exp_q.size() != 0);
      check("gnt0", bus.GNT0, m_gnt0);
      check("gnt1", bus.GNT1, m_gnt1);
      check("gnt_excl", bus.GNT0 & bus.GNT1, 1'b0);
      check("state_active", state_dbg != 2'd0, exp_q.size() != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_grant(input int budget, output int which, output int at);
    which = -1;
    at = 0;
    for (int i = 0; i < budget && which < 0; i++) begin
      @(negedge CLK);
      if (bus.GNT0 || bus.GNT1) begin
        which = bus.GNT1 ? 1 : 0;
        at = cyc;
      end
    end
    if (which < 0) check("grant_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_idle(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      @(negedge CLK);
      if (!bus.BUSY) at = cyc;
    end
    if (at < 0) check("idle_timeout", 1'b0, 1'b1);
  endtask

  // ---------------- directed stimulus ----------------
  logic [FW-1:0] exp_seq;
  int who, at, idle_at, prev_at, hold;
  int gwho[4];
  int gcyc[4];

  initial begin
    bus.REQ0 = 1'b0; bus.REQ1 = 1'b0; bus.DATA0 = '0; bus.DATA1 = '0;
    bus2.REQ0 = 1'b0; bus2.REQ1 = 1'b0; bus2.DATA0 = '0; bus2.DATA1 = '0;

    // Reset held 3 edges with REQ0 pending: nothing may be granted.
    RESET = 1'b0;
    bus.REQ0 = 1'b1;
    bus.DATA0 = 12'b101001100101;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check_en = 1'b1;
      check("rst_txd", bus.TXD, 1'b1);
      check("rst_busy", bus.BUSY, 1'b0);
      check("rst_gnt", {bus.GNT0, bus.GNT1}, 2'b00);
    end
    RESET = 1'b1;

    // Single frame, granted on the first edge after release.
    prev_at = cyc;
    wait_grant(5, who, at);
    check("first_gnt_who", who, 0);
    check("first_gnt_delay", at - prev_at, 1);
    bus.REQ0 = 1'b0;
    exp_seq = 12'b101001100101;
    for (int k = 0; k < FW * BD; k++) begin
      if (k > 0) @(negedge CLK);
      check("single_txd", bus.TXD, exp_seq[FW - 1 - k / BD]);
      check("single_busy", bus.BUSY, 1'b1);
      if (k == 1) check("single_gnt_width", bus.GNT0, 1'b0);
    end
    for (int k = 0; k < GB * BD; k++) begin
      @(negedge CLK);
      check("gap_txd", bus.TXD, 1'b1);
      check("gap_busy", bus.BUSY, 1'b1);
    end
    @(negedge CLK);
    check("single_end_busy", bus.BUSY, 1'b0);

    // Drop: all-ones frame from requester 1 is granted but never sent.
    bus.DATA1 = 12'hFFF;
    bus.REQ1 = 1'b1;
    wait_grant(5, who, at);
    check("drop_who", who, 1);
    check("drop_txd", bus.TXD, 1'b1);
    check("drop_busy", bus.BUSY, 1'b0);
    prev_at = at;

    // Contention right after the drop: PRI now favours 0, then alternates.
    bus.DATA0 = 12'h3C5;
    bus.DATA1 = 12'h6A9;
    bus.REQ0 = 1'b1;
    for (int n = 0; n < 4; n++) begin
      wait_grant(70, who, at);
      gwho[n] = who;
      gcyc[n] = at;
    end
    bus.REQ0 = 1'b0;
    bus.REQ1 = 1'b0;
    check("after_drop_delay", gcyc[0] - prev_at, 1);
    for (int n = 0; n < 4; n++) check("rr_order", gwho[n], n % 2);
    for (int n = 1; n < 4; n++) check("rr_spacing", gcyc[n] - gcyc[n - 1], 57);

    // Mid-frame reset while bit 5 is on the line.
    repeat (25) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check("midrst_txd", bus.TXD, 1'b1);
    check("midrst_busy", bus.BUSY, 1'b0);
    RESET = 1'b1;
    bus.DATA0 = 12'h2D3;
    bus.REQ0 = 1'b1;
    prev_at = cyc;
    wait_grant(5, who, at);
    check("midrst_regrant", at - prev_at, 1);
    check("midrst_bit11", bus.TXD, 1'b0);
    bus.REQ0 = 1'b0;
    repeat (8) @(negedge CLK);
    check("midrst_bit9", bus.TXD, 1'b1);

    // Late request raised during the gap waits for IDLE.
    repeat (42) @(negedge CLK);
    check("late_in_gap", bus.BUSY, 1'b1);
    bus.DATA1 = 12'h1E7;
    bus.REQ1 = 1'b1;
    wait_idle(20, idle_at);
    wait_grant(5, who, at);
    check("late_who", who, 1);
    check("late_delay", at - idle_at, 1);
    bus.REQ1 = 1'b0;
    wait_idle(80, idle_at);

    // Default parameters: reset state, then the first bit lasts BAUD_DIV cycles.
    check("dflt_rst_txd", bus2.TXD, 1'b1);
    check("dflt_rst_busy", bus2.BUSY, 1'b0);
    check("dflt_rst_gnt", bus2.GNT0, 1'b0);
    rst2 = 1'b1;
    bus2.DATA0 = 12'h5A5;
    bus2.REQ0 = 1'b1;
    @(negedge CLK);
    check("dflt_gnt", bus2.GNT0, 1'b1);
    check("dflt_bit11", bus2.TXD, 1'b0);
    check("dflt_state", state_dbg2 != 2'd0, 1'b1);
    bus2.REQ0 = 1'b0;
    hold = 1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge CLK);
      if (bus2.TXD !== 1'b0) break;
      hold++;
    end
    check("dflt_bit_len", hold, 5208);
    check("dflt_bit10", bus2.TXD, 1'b1);

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog at cycle %0d: actual=running required=finished", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
